peak_packer: RTL and testbench

PEAK_PACKER -- requirements
Module: peak_packer

---
 rtl/peak_packer.sv | 192 +++++++++++++++++++
 tb/tb_peak_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_packer.sv
// peak_packer: double-buffers peak records and serializes each committed frame as SYNC, seq, record bytes, XOR checksum.
module peak_packer #(
    parameter int NPEAKS = 4,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    input  logic [23:0] sink_freq,
    input  logic [15:0] sink_phaseA,
    input  logic [15:0] sink_phaseB,
    output logic        source_valid,
    input  logic        source_ready,
    output logic [7:0]  source_data,
    output logic        source_sop,
    output logic        source_eop,
    output logic [7:0]  drop_count
);
    localparam int IW = $clog2(NPEAKS + 1);
    localparam int RW = NPEAKS > 1 ? $clog2(NPEAKS) : 1;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_SEQ, ST_DATA, ST_CSUM} state_t;
    state_t state_q, state_d;
    logic [1:0] full_q, full_d, rel_v, free_v, n_drop;
    logic tx_q, tx_d, bank_q, bank_d, cap_q, cap_d, skip_q, skip_d;
    logic valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [7:0] data_q, data_d, csum_q, csum_d, seq_q, seq_d, drop_q, drop_d, nxt;
    logic [RW-1:0] rec_q, rec_d, nrec, rd_rec, widx;
    logic [2:0] byte_q, byte_d, nbyte, rd_byte;
    logic [IW-1:0] idx_q, idx_d;
    logic [6:0][7:0] mem_q [2][NPEAKS];
    logic [6:0][7:0] rd_bytes;
    logic we, wbank, sel, commit, cbank, last, rel, other;
    always_comb begin
        rel = state_q == ST_CSUM && source_ready;
        last = byte_q == 3'd6 && rec_q == RW'(NPEAKS - 1);
        nrec = byte_q == 3'd6 ? rec_q + RW'(1) : rec_q;
        nbyte = byte_q == 3'd6 ? 3'd0 : byte_q + 3'd1;
        rd_rec = state_q == ST_SEQ ? '0 : nrec;
        rd_byte = state_q == ST_SEQ ? 3'd0 : nbyte;
        rd_bytes = mem_q[tx_q][rd_rec];
        nxt = rd_bytes[3'd6 - rd_byte];
        other = full_q[~tx_q];
        state_d = state_q;
        tx_d = tx_q;
        rec_d = rec_q;
        byte_d = byte_q;
        csum_d = csum_q;
        seq_d = seq_q;
        valid_d = valid_q;
        data_d = data_q;
        sop_d = sop_q;
        eop_d = eop_q;
        if (state_q == ST_IDLE) begin
            if (|full_q) begin
                state_d = ST_SYNC;
                tx_d = ~full_q[0];
                valid_d = 1'b1;
                data_d = SYNC;
                sop_d = 1'b1;
                eop_d = 1'b0;
                csum_d = SYNC;
            end
        end else if (source_ready) begin
            unique case (state_q)
                ST_SYNC: begin
                    state_d = ST_SEQ;
                    data_d = seq_q;
                    sop_d = 1'b0;
                    csum_d = csum_q ^ seq_q;
                end
                ST_SEQ: begin
                    state_d = ST_DATA;
                    rec_d = '0;
                    byte_d = 3'd0;
                    data_d = nxt;
                    csum_d = csum_q ^ nxt;
                end
                ST_DATA: begin
                    state_d = last ? ST_CSUM : ST_DATA;
                    rec_d = nrec;
                    byte_d = nbyte;
                    data_d = last ? csum_q : nxt;
                    eop_d = last;
                    csum_d = last ? csum_q : csum_q ^ nxt;
                end
                ST_CSUM: begin
                    // the other bank is already committed: start its SYNC with no idle cycle
                    state_d = other ? ST_SYNC : ST_IDLE;
                    tx_d = ~tx_q;
                    seq_d = seq_q + 8'd1;
                    valid_d = other;
                    sop_d = other;
                    eop_d = 1'b0;
                    data_d = other ? SYNC : 8'h00;
                    csum_d = SYNC;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
    always_comb begin
        rel_v = {rel & tx_q, rel & ~tx_q};
        free_v = ~full_q | rel_v;
        sel = ~free_v[0];
        cap_d = cap_q;
        skip_d = skip_q;
        bank_d = bank_q;
        idx_d = idx_q;
        n_drop = 2'd0;
        commit = 1'b0;
        we = 1'b0;
        wbank = sink_sop ? sel : bank_q;
        widx = sink_sop ? '0 : RW'(idx_q);
        if (sink_valid) begin
            if (sink_sop) begin
                n_drop = |free_v ? 2'(cap_q) + 2'(sink_eop && NPEAKS != 1) : 2'd1;
                we = |free_v;
                commit = |free_v && sink_eop && NPEAKS == 1;
                cap_d = |free_v && !sink_eop;
                skip_d = !(|free_v) && !sink_eop;
                bank_d = sel;
                idx_d = IW'(1);
            end else if (cap_q) begin
                if (idx_q == IW'(NPEAKS)) begin
                    n_drop = 2'd1;
                    cap_d = 1'b0;
                    skip_d = !sink_eop;
                end else begin
                    we = 1'b1;
                    idx_d = idx_q + IW'(1);
                    commit = sink_eop && idx_q == IW'(NPEAKS - 1);
                    n_drop = 2'(sink_eop && idx_q != IW'(NPEAKS - 1));
                    cap_d = !sink_eop;
                end
            end else begin
                // a stray frame counts once; the rest of it is skipped until its eop
                n_drop = 2'(!skip_q);
                skip_d = !sink_eop;
            end
        end
        cbank = wbank;
        full_d = (full_q & ~rel_v) | (commit ? (cbank ? 2'b10 : 2'b01) : 2'b00);
        drop_d = drop_q > 8'hFF - 8'(n_drop) ? 8'hFF : drop_q + 8'(n_drop);
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[wbank][widx] <= {sink_freq, sink_phaseA, sink_phaseB};
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            full_q <= 2'b00;
            tx_q <= 1'b0;
            rec_q <= '0;
            byte_q <= 3'd0;
            csum_q <= 8'h00;
            seq_q <= 8'h00;
            valid_q <= 1'b0;
            data_q <= 8'h00;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            cap_q <= 1'b0;
            skip_q <= 1'b0;
            bank_q <= 1'b0;
            idx_q <= '0;
            drop_q <= 8'h00;
        end else begin
            state_q <= state_d;
            full_q <= full_d;
            tx_q <= tx_d;
            rec_q <= rec_d;
            byte_q <= byte_d;
            csum_q <= csum_d;
            seq_q <= seq_d;
            valid_q <= valid_d;
            data_q <= data_d;
            sop_q <= sop_d;
            eop_q <= eop_d;
            cap_q <= cap_d;
            skip_q <= skip_d;
            bank_q <= bank_d;
            idx_q <= idx_d;
            drop_q <= drop_d;
        end
    end
    assign source_valid = valid_q;
    assign source_data = data_q;
    assign source_sop = sop_q;
    assign source_eop = eop_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_peak_packer.sv
// tb_peak_packer: directed vectors against an NPEAKS=1 and an NPEAKS=4 instance sharing stimulus.
module tb_peak_packer;
    logic clk = 1'b0, reset = 1'b0, ready = 1'b0, sel4 = 1'b0;
    logic sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic [23:0] sink_freq = '0;
    logic [15:0] sink_phaseA = '0, sink_phaseB = '0;
    logic v1, v4, s1, s4, e1, e4, o_valid, o_sop, o_eop;
    logic [7:0] d1, d4, dc1, dc4, o_data, o_drop;
    int tests = 0, fails = 0, ncyc;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic [1:0] gfl [$];
    logic [55:0] fr [4];
    typedef struct {
        logic [23:0] f;
        logic [15:0] a, b;
        logic [7:0] sq, cs;
    } vec_t;
    vec_t tv [4];
    bit seen;
    always #5 clk = ~clk;
    peak_packer #(.NPEAKS(1)) u1 (.clk(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_freq(sink_freq), .sink_phaseA(sink_phaseA), .sink_phaseB(sink_phaseB),
        .source_valid(v1), .source_ready(ready), .source_data(d1), .source_sop(s1), .source_eop(e1),
        .drop_count(dc1));
    peak_packer #(.NPEAKS(4)) u4 (.clk(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_freq(sink_freq), .sink_phaseA(sink_phaseA), .sink_phaseB(sink_phaseB),
        .source_valid(v4), .source_ready(ready), .source_data(d4), .source_sop(s4), .source_eop(e4),
        .drop_count(dc4));
    assign o_valid = sel4 ? v4 : v1;
    assign o_sop = sel4 ? s4 : s1;
    assign o_eop = sel4 ? e4 : e1;
    assign o_data = sel4 ? d4 : d1;
    assign o_drop = sel4 ? dc4 : dc1;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill(int base, int n);
        for (int i = 0; i < n; i++) fr[i] = {8'(base), 8'(i), 40'hC35A960FE1};
    endtask

    task automatic send(int n, int eop_at);
        for (int i = 0; i < n; i++) begin
            sink_valid = 1'b1;
            sink_sop = i == 0;
            sink_eop = i == eop_at;
            {sink_freq, sink_phaseA, sink_phaseB} = fr[i];
            @(negedge clk);
        end
        sink_valid = 1'b0;
        sink_sop = 1'b0;
        sink_eop = 1'b0;
    endtask

    task automatic mk_exp(logic [7:0] sq, int n);
        logic [7:0] x, b;
        x = 8'hA5 ^ sq;
        exp_q.push_back(8'hA5);
        exp_q.push_back(sq);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 7; k++) begin
                b = fr[i][55-8*k -: 8];
                x ^= b;
                exp_q.push_back(b);
            end
        exp_q.push_back(x);
    endtask

    task automatic collect(int nb, bit tog);
        int k = 0;
        bit st = 0;
        logic [10:0] held = '0;
        ncyc = 0;
        while (got.size() < nb && ncyc < 3000) begin
            ready = tog ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            k++;
            if (st) chk("stall_hold", {o_valid, o_sop, o_eop, o_data}, held);
            if (o_valid && ready) begin
                got.push_back(o_data);
                gfl.push_back({o_sop, o_eop});
            end
            st = o_valid && !ready;
            held = {o_valid, o_sop, o_eop, o_data};
            ncyc++;
            @(negedge clk);
        end
        chk("byte_count", got.size(), nb);
    endtask

    task automatic cmp(int flen);
        logic [1:0] ef;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j >= got.size()) begin
                chk("missing_bytes", got.size(), exp_q.size());
                break;
            end
            ef = {(j % flen) == 0, (j % flen) == flen - 1};
            chk($sformatf("byte%0d", j), got[j], exp_q[j]);
            chk($sformatf("sop_eop%0d", j), gfl[j], ef);
        end
    endtask

    task automatic clear();
        got.delete();
        gfl.delete();
        exp_q.delete();
    endtask

    initial begin
        tv[0] = '{24'h0003E8, 16'h1234, 16'hEDCC, 8'h00, 8'h49};
        tv[1] = '{24'h000000, 16'h0000, 16'h0000, 8'h01, 8'hA4};
        tv[2] = '{24'hFFFFFF, 16'hFFFF, 16'hFFFF, 8'h02, 8'h58};
        tv[3] = '{24'h123456, 16'h789A, 16'hBCDE, 8'h03, 8'h56};
        repeat (2) @(negedge clk);
        chk("rst_valid", v4, 0);
        chk("rst_sop", s4, 0);
        chk("rst_eop", e4, 0);
        chk("rst_data", d4, 8'h00);
        chk("rst_drop", dc4, 8'h00);
        chk("rst_valid1", v1, 0);
        chk("rst_drop1", dc1, 8'h00);
        reset = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        // single-record frames, seq advancing across the table
        for (int v = 0; v < 4; v++) begin
            clear();
            fr[0] = {tv[v].f, tv[v].a, tv[v].b};
            mk_exp(tv[v].sq, 1);
            send(1, 0);
            chk("latency_idle", o_valid, 0);
            @(negedge clk);
            chk("latency_valid", o_valid, 1);
            collect(10, 0);
            cmp(10);
            if (got.size() > 9) chk("csum_table", got[9], tv[v].cs);
        end
        chk("drop_clean1", o_drop, 0);
        // same frame under a 1,0,0,1 ready pattern
        do_reset();
        clear();
        fr[0] = {tv[0].f, tv[0].a, tv[0].b};
        mk_exp(8'h00, 1);
        send(1, 0);
        collect(10, 1);
        cmp(10);
        // two buffered frames, third dropped, then back-to-back drain
        sel4 = 1'b1;
        ready = 1'b0;
        do_reset();
        clear();
        fill(1, 4);
        mk_exp(8'h00, 4);
        send(4, 3);
        fill(2, 4);
        mk_exp(8'h01, 4);
        send(4, 3);
        fill(3, 4);
        send(4, 3);
        chk("drop_third", o_drop, 1);
        chk("stall_valid", o_valid, 1);
        chk("stall_sync", o_data, 8'hA5);
        chk("stall_sop", o_sop, 1);
        collect(62, 0);
        chk("back_to_back_cycles", ncyc, 62);
        cmp(31);
        seen = 0;
        repeat (6) begin
            seen |= o_valid;
            @(negedge clk);
        end
        chk("third_not_sent", seen, 0);
        // eop on the third record
        do_reset();
        clear();
        fill(4, 4);
        send(3, 2);
        seen = 0;
        repeat (10) begin
            seen |= o_valid;
            @(negedge clk);
        end
        chk("short_no_output", seen, 0);
        chk("short_drop", o_drop, 1);
        fill(5, 4);
        mk_exp(8'h00, 4);
        send(4, 3);
        collect(31, 0);
        cmp(31);
        chk("short_drop_after", o_drop, 1);
        // reset asserted while the 5th byte is on the bus
        do_reset();
        clear();
        fill(6, 4);
        send(4, 3);
        collect(4, 0);
        chk("fifth_valid", o_valid, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", o_valid, 0);
        @(negedge clk);
        chk("rst_mid_data", o_data, 8'h00);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            seen |= o_valid;
            @(negedge clk);
        end
        chk("rst_mid_silent", seen, 0);
        clear();
        fill(7, 4);
        mk_exp(8'h00, 4);
        send(4, 3);
        collect(31, 0);
        cmp(31);
        // checksum transfer coincides with sop while both banks are full
        sel4 = 1'b0;
        ready = 1'b0;
        do_reset();
        clear();
        fr[0] = {tv[0].f, tv[0].a, tv[0].b};
        mk_exp(8'h00, 1);
        send(1, 0);
        fr[0] = {tv[1].f, tv[1].a, tv[1].b};
        mk_exp(8'h01, 1);
        send(1, 0);
        fr[0] = {tv[3].f, tv[3].a, tv[3].b};
        mk_exp(8'h02, 1);
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) begin
                sink_valid = 1'b1;
                sink_sop = 1'b1;
                sink_eop = 1'b1;
                {sink_freq, sink_phaseA, sink_phaseB} = fr[0];
            end
            got.push_back(o_data);
            gfl.push_back({o_sop, o_eop});
            @(negedge clk);
        end
        sink_valid = 1'b0;
        sink_sop = 1'b0;
        sink_eop = 1'b0;
        chk("free_same_cycle_drop", o_drop, 0);
        collect(30, 0);
        cmp(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
